bitstream_packer: RTL and testbench
===================================

# bitstream_packer

Packs variable-length code fragments (0–32 bits per cycle) into a continuous MSB-first bit stream and emits it as 32-bit words. It sits at the tail of the MJPEG encoder, after the header/footer generator and the per-component entropy encoders, which are OR-multiplexed onto its input. It also reports how many bits are missing to the next byte boundary, so the upstream logic can pad with 1-bits before markers.

## Interface
Parameters: none (widths fixed; see Structure).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ilength  in  6  number of valid bits in idata this cycle, 0..32; 0 = no input.
- idata  in  32  code bits, right-aligned: bit ilength-1 is sent first, bit 0 last; bits ≥ ilength are don't-care.
- rest  out  3  (8 − pending_count mod 8) mod 8; bits needed to reach byte alignment.
- ovalid  out  1  one-cycle strobe, odata holds a complete word.
- odata  out  32  packed word; bit 31 is the earliest stream bit, bits[31:24] the first byte.

## Operation
- Internal state: pending buffer (≥63 bits) plus pending_count (0..31 between cycles).
- Each cycle with ilength = n > 0: mask idata to its low n bits and append them after the pending bits. total = pending_count + n.
- If total ≥ 32: emit the oldest 32 bits as odata with ovalid = 1. Keep the remaining total − 32 bits (0..31) as pending.
- Else: keep all total bits pending, with ovalid = 0.
- ilength = 0: state unchanged, ovalid = 0.
- ilength 33..63 is illegal. The block treats it as 32.
- No byte stuffing (0xFF→0xFF00). Markers and entropy data pass verbatim; stuffing is the upstream encoder's responsibility.
- No flush input. Partial words remain pending until later input completes them.
- No backpressure. One fragment is accepted every cycle, unconditionally.
- Reset: pending_count = 0, buffer cleared, ovalid = 0, odata = 0, rest = 0. A reset mid-operation discards pending bits, and no partial word is emitted.

## Timing
- Throughput: one fragment per cycle, at most one word per cycle (guaranteed since pending < 32 and n ≤ 32).
- Latency: ovalid/odata are registered and asserted the cycle after the input that completes the word. ovalid is low on all other cycles. odata holds its last value when ovalid = 0.
- rest is registered and reflects all fragments accepted up to and including the previous cycle, i.e. it is valid the cycle after the last input.
- Simultaneous rst and ilength ≠ 0: rst wins and the input is dropped.

## Structure
- Shared package constants: WORD_W = 32, LEN_W = 6, REST_W = 3, BUF_W = 64.
- One natural sub-module, bitstream_shifter: a combinational mask-and-left-shift that places n masked bits at offset (BUF_W − pending_count − n) in the 64-bit buffer. The top level holds the registers and the word-emit/shift-down logic.
- Target size: about 120–200 lines.

## Test plan
- Reset: hold rst for 3 cycles with ilength = 32 driven → ovalid = 0, odata = 0, rest = 0 throughout and one cycle after release.
- Byte fragments: ilength = 8 with 0xFF, 0xD8, 0xFF, 0xE0 on consecutive cycles → the cycle after the 4th, ovalid = 1 and odata = 0xFFD8FFE0; rest = 0; ovalid = 0 on all earlier cycles.
- Odd lengths and rest:
  - 3 bits 0b101 → rest = 5 next cycle.
  - 5 bits 0x1F → rest = 0.
  - 24 bits 0xABCDEF → odata = 0xBFABCDEF.
- Full-width straddle:
  - 4 bits 0xA, then 32 bits 0x12345678 → odata = 0xA1234567, rest = 4.
  - Then 28 bits 0x0000000 → odata = 0x80000000.
- Masking: ilength = 4, idata = 0xFFFFFFF5, followed by seven more 4-bit 0x5 fragments → odata = 0x55555555; garbage upper bits never appear.
- Alignment padding and reset mid-word:
  - 13 bits pending → rest = 3. Then 3 bits 0xFF (masked to 0b111) → rest = 0.
  - Assert rst with 16 bits pending, then 32 bits 0xCAFEBABE → odata = 0xCAFEBABE, with no stale bits.

Source files
------------

// File: rtl/bitstream_packer_pkg.sv
// Shared widths and helpers for the MJPEG tail bit-stream packer.
package bitstream_packer_pkg;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 6;
  localparam int REST_W = 3;
  localparam int BUF_W  = 64;
  localparam int CNT_W  = 5;

  typedef logic [BUF_W-1:0] buf_t;

  // Bits still needed to reach the next byte boundary: (-count) mod 8.
  function automatic logic [REST_W-1:0] bits_to_byte(input logic [CNT_W-1:0] cnt);
    return 3'(3'd0 - cnt[2:0]);
  endfunction
endpackage

// File: rtl/bitstream_shifter.sv
// Masks a right-aligned fragment to its length and drops it just below the pending bits.
module bitstream_shifter
  import bitstream_packer_pkg::*;
(
  input  logic [LEN_W-1:0]  len,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [WORD_W-1:0] data,
  output buf_t              placed
);

  logic [BUF_W-1:0] mask_s;
  logic [6:0]       shamt_s;

  // Offset is BUF_W - cnt - len; a shift of 64 (empty fragment, empty buffer) yields zero.
  always_comb begin
    mask_s  = ~({BUF_W{1'b1}} << len);
    shamt_s = 7'd64 - {2'b00, cnt} - {1'b0, len};
    placed  = ({32'd0, data} & mask_s) << shamt_s;
  end

endmodule

// File: rtl/bitstream_packer.sv
// Packs 0..32-bit code fragments MSB-first into 32-bit words and reports byte-alignment slack.
module bitstream_packer
  import bitstream_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  ilength,
  input  logic [WORD_W-1:0] idata,
  output logic [REST_W-1:0] rest,
  output logic              ovalid,
  output logic [WORD_W-1:0] odata
);

  buf_t              buf_r;
  buf_t              placed_s;
  buf_t              merged_s;
  buf_t              buf_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [LEN_W-1:0]  len_s;
  logic [LEN_W-1:0]  total_s;
  logic              word_s;
  logic              ovalid_r;
  logic [WORD_W-1:0] odata_r;
  logic [REST_W-1:0] rest_r;

  // Out-of-range lengths are treated as a full word.
  always_comb begin
    if (ilength > 6'd32) begin
      len_s = 6'd32;
    end else begin
      len_s = ilength;
    end
  end

  bitstream_shifter u_shifter (
    .len    (len_s),
    .cnt    (cnt_r),
    .data   (idata),
    .placed (placed_s)
  );

  // Pending bits live MSB-aligned in buf_r; a completed word is taken from the top half.
  always_comb begin
    merged_s   = buf_r | placed_s;
    total_s    = {1'b0, cnt_r} + len_s;
    buf_next_s = buf_r;
    cnt_next_s = cnt_r;
    word_s     = 1'b0;
    if (len_s != 6'd0) begin
      if (total_s >= 6'd32) begin
        word_s     = 1'b1;
        buf_next_s = {merged_s[31:0], 32'd0};
        cnt_next_s = 5'(total_s - 6'd32);
      end else begin
        buf_next_s = merged_s;
        cnt_next_s = total_s[4:0];
      end
    end else begin
      word_s = 1'b0;
    end
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r    <= '0;
      cnt_r    <= 5'd0;
      ovalid_r <= 1'b0;
      odata_r  <= 32'd0;
      rest_r   <= 3'd0;
    end else begin
      buf_r    <= buf_next_s;
      cnt_r    <= cnt_next_s;
      ovalid_r <= word_s;
      if (word_s) begin
        odata_r <= merged_s[63:32];
      end else begin
        odata_r <= odata_r;
      end
      rest_r   <= bits_to_byte(cnt_next_s);
    end
  end

  assign ovalid = ovalid_r;
  assign odata  = odata_r;
  assign rest   = rest_r;

endmodule

// File: tb/tb_bitstream_packer.sv
// Randomized self-checking bench for bitstream_packer against a bit-queue reference model.
module tb_bitstream_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  ilength = 6'd0;
  logic [31:0] idata = 32'd0;
  logic [2:0]  rest;
  logic        ovalid;
  logic [31:0] odata;

  int          n_cmp = 0;
  int          n_bad = 0;

  bit          q[$];
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [2:0]  exp_rest;

  bitstream_packer dut (
    .clk     (clk),
    .rst     (rst),
    .ilength (ilength),
    .idata   (idata),
    .rest    (rest),
    .ovalid  (ovalid),
    .odata   (odata)
  );

  always #5 clk = ~clk;

  // Applies one cycle of input, advances the reference model, samples after the edge.
  task automatic step(input logic r, input int len, input logic [31:0] data);
    int n;
    logic [31:0] w;
    rst     = r;
    ilength = 6'(len);
    idata   = data;
    if (r) begin
      q.delete();
      exp_valid = 1'b0;
      exp_data  = 32'd0;
      exp_rest  = 3'd0;
    end else begin
      n = (len > 32) ? 32 : len;
      for (int i = n - 1; i >= 0; i--) q.push_back(data[i]);
      exp_valid = 1'b0;
      if (q.size() >= 32) begin
        w = 32'd0;
        for (int i = 0; i < 32; i++) w = {w[30:0], q.pop_front()};
        exp_data  = w;
        exp_valid = 1'b1;
      end
      exp_rest = 3'((8 - (q.size() % 8)) % 8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32, $urandom);
      n_cmp++;
      if ({ovalid, odata, rest} !== {1'b0, 32'd0, 3'd0}) begin
        n_bad++;
        $display("FAIL reset[%0d]: got v=%b d=%h r=%0d want v=0 d=0 r=0", i, ovalid, odata, rest);
      end
    end
    step(1'b0, 0, 32'd0);
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b0, 32'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_release: got v=%b d=%h r=%0d want v=0 d=0 r=0", ovalid, odata, rest);
    end
  endtask

  task automatic test_bytes();
    logic [31:0] bytes [4] = '{32'hFF, 32'hD8, 32'hFF, 32'hE0};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8, bytes[i] | 32'hABCDEF00);
      n_cmp++;
      if ({ovalid, odata, rest} !== {exp_valid, exp_data, exp_rest}) begin
        n_bad++;
        $display("FAIL bytes[%0d]: got v=%b d=%h r=%0d want v=%b d=%h r=%0d",
                 i, ovalid, odata, rest, exp_valid, exp_data, exp_rest);
      end
    end
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b1, 32'hFFD8FFE0, 3'd0}) begin
      n_bad++;
      $display("FAIL bytes_word: got v=%b d=%h r=%0d want v=1 d=ffd8ffe0 r=0", ovalid, odata, rest);
    end
  endtask

  task automatic test_odd_rest();
    step(1'b0, 3, 32'h5);
    n_cmp++;
    if ({ovalid, rest} !== {1'b0, 3'd5}) begin
      n_bad++;
      $display("FAIL odd_3: got v=%b r=%0d want v=0 r=5", ovalid, rest);
    end
    step(1'b0, 5, 32'h1F);
    n_cmp++;
    if ({ovalid, rest} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL odd_5: got v=%b r=%0d want v=0 r=0", ovalid, rest);
    end
    step(1'b0, 24, 32'h00ABCDEF);
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b1, 32'hBFABCDEF, 3'd0}) begin
      n_bad++;
      $display("FAIL odd_24: got v=%b d=%h r=%0d want v=1 d=bfabcdef r=0", ovalid, odata, rest);
    end
  endtask

  task automatic test_straddle();
    step(1'b0, 4, 32'hA);
    step(1'b0, 32, 32'h12345678);
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b1, 32'hA1234567, 3'd4}) begin
      n_bad++;
      $display("FAIL straddle_32: got v=%b d=%h r=%0d want v=1 d=a1234567 r=4", ovalid, odata, rest);
    end
    step(1'b0, 28, 32'h0);
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b1, 32'h80000000, 3'd0}) begin
      n_bad++;
      $display("FAIL straddle_28: got v=%b d=%h r=%0d want v=1 d=80000000 r=0", ovalid, odata, rest);
    end
  endtask

  task automatic test_masking();
    step(1'b0, 4, 32'hFFFFFFF5);
    for (int i = 0; i < 7; i++) step(1'b0, 4, 32'h5 | ($urandom << 4));
    n_cmp++;
    if ({ovalid, odata} !== {1'b1, 32'h55555555}) begin
      n_bad++;
      $display("FAIL masking: got v=%b d=%h want v=1 d=55555555", ovalid, odata);
    end
  endtask

  task automatic test_padding_reset();
    step(1'b0, 13, $urandom);
    n_cmp++;
    if (rest !== 3'd3) begin
      n_bad++;
      $display("FAIL pad_13: got r=%0d want r=3", rest);
    end
    step(1'b0, 3, 32'hFF);
    n_cmp++;
    if (rest !== 3'd0) begin
      n_bad++;
      $display("FAIL pad_3: got r=%0d want r=0", rest);
    end
    step(1'b1, 32, 32'h12345678);
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b0, 32'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL midword_rst: got v=%b d=%h r=%0d want v=0 d=0 r=0", ovalid, odata, rest);
    end
    step(1'b0, 32, 32'hCAFEBABE);
    n_cmp++;
    if ({ovalid, odata, rest} !== {1'b1, 32'hCAFEBABE, 3'd0}) begin
      n_bad++;
      $display("FAIL after_rst: got v=%b d=%h r=%0d want v=1 d=cafebabe r=0", ovalid, odata, rest);
    end
  endtask

  task automatic test_random();
    int sel;
    int len;
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 10)      len = 0;
      else if (sel < 20) len = int'($urandom_range(33, 63));
      else               len = int'($urandom_range(1, 32));
      step((sel == 99) ? 1'b1 : 1'b0, len, $urandom);
      n_cmp++;
      if ({ovalid, odata, rest} !== {exp_valid, exp_data, exp_rest}) begin
        n_bad++;
        $display("FAIL random[%0d] len=%0d: got v=%b d=%h r=%0d want v=%b d=%h r=%0d",
                 i, len, ovalid, odata, rest, exp_valid, exp_data, exp_rest);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bytes();
    test_odd_rest();
    test_straddle();
    test_masking();
    test_padding_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
